// File: rtl/wiphy_trx_ctrl.sv
// wiphy_trx_ctrl
// Half-duplex burst sequencer between the wiphy sample streams and the
// AD9361-style converter ports. Runs one TX burst (s_axis -> DAC ch0) or
// one RX capture (ADC ch0 -> m_axis) at a time. A programmable turnaround
// gap follows every burst, and the burst's done pulse is issued in the
// gap's last cycle.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_tx_len/rx_len     burst lengths, latched when a burst starts
//   cfg_gap               turnaround length, latched on GAP entry (0 acts as 1)
//   tx_start/rx_start     one-cycle requests (one-deep pending while busy)
//   abort                 return to IDLE and drop pending requests
//   err_clear             clear sticky tx_underflow / rx_overflow
//   busy                  sequencer not idle
//   tx_done/rx_done       one-cycle pulse at the end of the post-burst gap
//   s_axis_*              TX sample stream, {Q,I}
//   dac_*                 DAC channel 0 outputs (registered, latency 1)
//   adc_*                 ADC channel 0 inputs
//   m_axis_*              RX sample stream, {Q,I}, one-entry output register
module wiphy_trx_ctrl #(
  parameter int LEN_WIDTH = 16,
  parameter int GAP_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [LEN_WIDTH-1:0] cfg_tx_len,
  input  logic [LEN_WIDTH-1:0] cfg_rx_len,
  input  logic [GAP_WIDTH-1:0] cfg_gap,
  input  logic                 tx_start,
  input  logic                 rx_start,
  input  logic                 abort,
  input  logic                 err_clear,
  output logic                 busy,
  output logic                 tx_done,
  output logic                 rx_done,
  output logic                 tx_underflow,
  output logic                 rx_overflow,
  input  logic                 s_axis_tvalid,
  input  logic [31:0]          s_axis_tdata,
  output logic                 s_axis_tready,
  output logic                 dac_valid_i0,
  output logic                 dac_valid_q0,
  output logic [15:0]          dac_data_i0,
  output logic [15:0]          dac_data_q0,
  input  logic                 adc_valid_i0,
  input  logic [15:0]          adc_data_i0,
  input  logic [15:0]          adc_data_q0,
  output logic                 m_axis_tvalid,
  output logic [31:0]          m_axis_tdata,
  input  logic                 m_axis_tready
);

  typedef enum logic [1:0] {IDLE, TX, RX, GAP} state_t;

  state_t               state_reg, state_next;
  logic [LEN_WIDTH-1:0] cnt_reg, cnt_next;
  logic [GAP_WIDTH-1:0] gap_reg, gap_next;
  logic                 prev_tx_reg, prev_tx_next;  // 1: current GAP follows TX
  logic                 pend_tx_reg, pend_tx_next;
  logic                 pend_rx_reg, pend_rx_next;

  logic                 tx_done_c, rx_done_c;
  logic                 sel;
  logic                 req_tx, req_rx;

  logic                 tx_slot, rx_cap, m_drain;
  logic                 dac_valid_reg;
  logic [15:0]          dac_i_reg, dac_q_reg;
  logic                 m_valid_reg;
  logic [31:0]          m_data_reg;
  logic                 underflow_reg, overflow_reg;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      gap_reg     <= '0;
      prev_tx_reg <= 1'b0;
      pend_tx_reg <= 1'b0;
      pend_rx_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      gap_reg     <= gap_next;
      prev_tx_reg <= prev_tx_next;
      pend_tx_reg <= pend_tx_next;
      pend_rx_reg <= pend_rx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    gap_next     = gap_reg;
    prev_tx_next = prev_tx_reg;
    pend_tx_next = pend_tx_reg;
    pend_rx_next = pend_rx_reg;
    tx_done_c    = 1'b0;
    rx_done_c    = 1'b0;
    sel          = 1'b0;
    req_tx       = tx_start | pend_tx_reg;
    req_rx       = rx_start | pend_rx_reg;

    if (abort) begin
      state_next   = IDLE;
      pend_tx_next = 1'b0;
      pend_rx_next = 1'b0;
    end else begin
      // While busy, a start only records a one-deep pending request.
      if (state_reg != IDLE) begin
        pend_tx_next = req_tx;
        pend_rx_next = req_rx;
      end
      case (state_reg)
        IDLE: sel = 1'b1;
        TX: begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg <= LEN_WIDTH'(1)) begin
            state_next   = GAP;
            gap_next     = (cfg_gap == '0) ? GAP_WIDTH'(1) : cfg_gap;
            prev_tx_next = 1'b1;
          end
        end
        RX: begin
          if (adc_valid_i0) begin
            cnt_next = cnt_reg - 1'b1;
            if (cnt_reg <= LEN_WIDTH'(1)) begin
              state_next   = GAP;
              gap_next     = (cfg_gap == '0) ? GAP_WIDTH'(1) : cfg_gap;
              prev_tx_next = 1'b0;
            end
          end
        end
        GAP: begin
          if (gap_reg <= GAP_WIDTH'(1)) begin
            tx_done_c = prev_tx_reg;
            rx_done_c = ~prev_tx_reg;
            sel       = 1'b1;   // chain straight into the next burst
          end else begin
            gap_next = gap_reg - 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase

      // Burst selection, shared by IDLE and the last GAP cycle. TX wins;
      // a zero-length request is discarded rather than started.
      if (sel) begin
        if (req_tx && cfg_tx_len != '0) begin
          state_next   = TX;
          cnt_next     = cfg_tx_len;
          pend_tx_next = 1'b0;
          pend_rx_next = req_rx;
        end else if (req_rx && cfg_rx_len != '0) begin
          state_next   = RX;
          cnt_next     = cfg_rx_len;
          pend_tx_next = 1'b0;
          pend_rx_next = 1'b0;
        end else begin
          state_next   = IDLE;
          pend_tx_next = 1'b0;
          pend_rx_next = 1'b0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sample datapath
  // ---------------------------------------------------------------------
  assign tx_slot = (state_reg == TX) && !abort;
  assign rx_cap  = (state_reg == RX) && !abort && adc_valid_i0;
  assign m_drain = m_valid_reg && m_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      dac_valid_reg <= 1'b0;
      dac_i_reg     <= '0;
      dac_q_reg     <= '0;
      m_valid_reg   <= 1'b0;
      m_data_reg    <= '0;
      underflow_reg <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      // Every TX slot produces a DAC strobe; a missing beat sends zeros.
      dac_valid_reg <= tx_slot;
      dac_i_reg     <= (tx_slot && s_axis_tvalid) ? s_axis_tdata[15:0]  : 16'h0000;
      dac_q_reg     <= (tx_slot && s_axis_tvalid) ? s_axis_tdata[31:16] : 16'h0000;

      // Output register drains in any state; a capture may refill it in
      // the same cycle it drains.
      if (rx_cap && (!m_valid_reg || m_drain)) begin
        m_valid_reg <= 1'b1;
        m_data_reg  <= {adc_data_q0, adc_data_i0};
      end else if (m_drain) begin
        m_valid_reg <= 1'b0;
      end

      // Sticky flags: a new error in the clear cycle keeps the flag set.
      underflow_reg <= (tx_slot && !s_axis_tvalid) || (underflow_reg && !err_clear);
      overflow_reg  <= (rx_cap && m_valid_reg && !m_axis_tready) ||
                       (overflow_reg && !err_clear);
    end
  end

  assign busy          = (state_reg != IDLE);
  assign tx_done       = tx_done_c;
  assign rx_done       = rx_done_c;
  assign s_axis_tready = (state_reg == TX);
  assign dac_valid_i0  = dac_valid_reg;
  assign dac_valid_q0  = dac_valid_reg;
  assign dac_data_i0   = dac_i_reg;
  assign dac_data_q0   = dac_q_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tdata  = m_data_reg;
  assign tx_underflow  = underflow_reg;
  assign rx_overflow   = overflow_reg;

endmodule

// File: tb/tb_wiphy_trx_ctrl.sv
// Directed testbench for wiphy_trx_ctrl. Inputs change 1 ns after the
// rising edge; outputs are checked on the falling edge. "Cycle c" of a
// test is the clock period in which the test's c-th input vector is held.
module tb_wiphy_trx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cfg_tx_len, cfg_rx_len;
  logic [7:0]  cfg_gap;
  logic        tx_start, rx_start, abort, err_clear;
  logic        busy, tx_done, rx_done, tx_underflow, rx_overflow;
  logic        s_axis_tvalid, s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic        dac_valid_i0, dac_valid_q0;
  logic [15:0] dac_data_i0, dac_data_q0;
  logic        adc_valid_i0;
  logic [15:0] adc_data_i0, adc_data_q0;
  logic        m_axis_tvalid, m_axis_tready;
  logic [31:0] m_axis_tdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wiphy_trx_ctrl #(.LEN_WIDTH(16), .GAP_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .cfg_tx_len(cfg_tx_len), .cfg_rx_len(cfg_rx_len), .cfg_gap(cfg_gap),
    .tx_start(tx_start), .rx_start(rx_start), .abort(abort), .err_clear(err_clear),
    .busy(busy), .tx_done(tx_done), .rx_done(rx_done),
    .tx_underflow(tx_underflow), .rx_overflow(rx_overflow),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tready(s_axis_tready),
    .dac_valid_i0(dac_valid_i0), .dac_valid_q0(dac_valid_q0),
    .dac_data_i0(dac_data_i0), .dac_data_q0(dac_data_q0),
    .adc_valid_i0(adc_valid_i0), .adc_data_i0(adc_data_i0), .adc_data_q0(adc_data_q0),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tready(m_axis_tready)
  );

  task automatic idle_inputs();
    reset = 1'b0; tx_start = 1'b0; rx_start = 1'b0; abort = 1'b0; err_clear = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0;
    adc_valid_i0 = 1'b0; adc_data_i0 = '0; adc_data_q0 = '0; m_axis_tready = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] act;
    idle_inputs();
    cfg_tx_len = 16'd0; cfg_rx_len = 16'd0; cfg_gap = 8'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    act = {busy, tx_done, rx_done, tx_underflow, rx_overflow, s_axis_tready,
           dac_valid_i0, dac_valid_q0, m_axis_tvalid, |dac_data_i0, |dac_data_q0, |m_axis_tdata};
    n_cmp++;
    if (act !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want %b", act, 12'h000);
    end
    $display("test_reset: outputs after reset %b", act);
    @(posedge clk); #1;
  endtask

  task automatic test_basic_tx();
    logic [5:0] act, exp;
    logic [31:0] dac, edac;
    cfg_tx_len = 16'd4; cfg_gap = 8'd3;
    for (int c = 0; c <= 8; c++) begin
      tx_start = (c == 0); s_axis_tvalid = 1'b1; s_axis_tdata = {16'(c), 16'(c * 16)};
      @(negedge clk);
      exp = {(c >= 1 && c <= 7), (c >= 1 && c <= 4), (c >= 2 && c <= 5), (c >= 2 && c <= 5),
             (c == 7), 1'b0};
      act = {busy, s_axis_tready, dac_valid_i0, dac_valid_q0, tx_done, tx_underflow};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL basic_tx_ctl c=%0d: got %b want %b", c, act, exp);
      end
      if (c >= 2 && c <= 5) begin
        edac = {16'(c - 1), 16'((c - 1) * 16)};
        dac  = {dac_data_q0, dac_data_i0};
        n_cmp++;
        if (dac !== edac) begin
          n_bad++;
          $display("FAIL basic_tx_data c=%0d: got %h want %h", c, dac, edac);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("test_basic_tx: 4-sample burst, gap 3 done");
  endtask

  task automatic test_tx_underflow();
    logic [4:0] act, exp;
    logic [31:0] dac, edac;
    cfg_tx_len = 16'd3; cfg_gap = 8'd1;
    for (int c = 0; c <= 7; c++) begin
      tx_start = (c == 0); s_axis_tvalid = (c != 2); s_axis_tdata = {16'(c), 16'(c * 16)};
      err_clear = (c == 6);
      @(negedge clk);
      exp = {(c >= 1 && c <= 4), (c >= 2 && c <= 4), (c >= 2 && c <= 4), (c == 4),
             (c >= 3 && c <= 6)};
      act = {busy, dac_valid_i0, dac_valid_q0, tx_done, tx_underflow};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL underflow_ctl c=%0d: got %b want %b", c, act, exp);
      end
      if (c >= 2 && c <= 4) begin
        edac = (c == 3) ? 32'h0 : {16'(c - 1), 16'((c - 1) * 16)};
        dac  = {dac_data_q0, dac_data_i0};
        n_cmp++;
        if (dac !== edac) begin
          n_bad++;
          $display("FAIL underflow_data c=%0d: got %h want %h", c, dac, edac);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("test_tx_underflow: missing beat sent as zero");
  endtask

  task automatic test_rx_backpressure();
    logic [3:0] act, exp;
    cfg_rx_len = 16'd4; cfg_gap = 8'd3;
    for (int c = 0; c <= 9; c++) begin
      rx_start = (c == 0); adc_valid_i0 = (c <= 4);
      adc_data_i0 = 16'h0100 + 16'(c); adc_data_q0 = 16'h0200 + 16'(c);
      m_axis_tready = (c == 5); err_clear = (c == 8);
      @(negedge clk);
      exp = {(c >= 1 && c <= 7), (c >= 2 && c <= 5), (c == 7), (c >= 3 && c <= 8)};
      act = {busy, m_axis_tvalid, rx_done, rx_overflow};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL rx_bp_ctl c=%0d: got %b want %b", c, act, exp);
      end
      if (c >= 2 && c <= 5) begin
        n_cmp++;
        if (m_axis_tdata !== 32'h0201_0101) begin
          n_bad++;
          $display("FAIL rx_bp_data c=%0d: got %h want %h", c, m_axis_tdata, 32'h0201_0101);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("test_rx_backpressure: first sample held, three dropped");
  endtask

  task automatic test_arbitration();
    logic [4:0] act, exp;
    cfg_tx_len = 16'd2; cfg_rx_len = 16'd2; cfg_gap = 8'd1;
    for (int c = 0; c <= 7; c++) begin
      tx_start = (c == 0); rx_start = (c == 0);
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'h1234_5678;
      adc_valid_i0 = 1'b1; adc_data_i0 = 16'h0A00 + 16'(c); adc_data_q0 = 16'h0B00 + 16'(c);
      m_axis_tready = 1'b1;
      @(negedge clk);
      exp = {(c >= 1 && c <= 6), (c == 1 || c == 2), (c == 3), (c == 6), (c == 5 || c == 6)};
      act = {busy, s_axis_tready, tx_done, rx_done, m_axis_tvalid};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL arb_ctl c=%0d: got %b want %b", c, act, exp);
      end
      if (c == 5) begin
        n_cmp++;
        if (m_axis_tdata !== 32'h0B04_0A04) begin
          n_bad++;
          $display("FAIL arb_rx_data c=%0d: got %h want %h", c, m_axis_tdata, 32'h0B04_0A04);
        end
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("test_arbitration: TX then RX back-to-back");
  endtask

  task automatic test_abort();
    logic [4:0] act, exp;
    cfg_tx_len = 16'd8; cfg_rx_len = 16'd4; cfg_gap = 8'd2;
    for (int c = 0; c <= 8; c++) begin
      tx_start = (c == 0); rx_start = (c == 1); abort = (c == 2);
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0055_00AA;
      adc_valid_i0 = 1'b1; m_axis_tready = 1'b1;
      @(negedge clk);
      exp = {(c == 1 || c == 2), (c == 1 || c == 2), (c == 2), 1'b0, 1'b0};
      act = {busy, s_axis_tready, dac_valid_i0, tx_done, rx_done};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL abort_ctl c=%0d: got %b want %b", c, act, exp);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("test_abort: aborted at slot 2, pending RX dropped");
  endtask

  task automatic test_reset_mid_rx();
    logic [7:0] act, exp;
    cfg_rx_len = 16'd4; cfg_tx_len = 16'd0; cfg_gap = 8'd2;
    for (int c = 0; c <= 8; c++) begin
      rx_start = (c == 0); tx_start = (c == 5); reset = (c == 3);
      adc_valid_i0 = (c <= 4); adc_data_i0 = 16'h7000 + 16'(c); adc_data_q0 = 16'h7100;
      m_axis_tready = 1'b0;
      @(negedge clk);
      if (c == 3) begin
        exp = 8'b1100_0000;
        act = {m_axis_tvalid, rx_overflow, 6'b0};
      end else if (c >= 4) begin
        exp = 8'h00;
        act = {busy, m_axis_tvalid, rx_overflow, rx_done, s_axis_tready, dac_valid_i0,
               |m_axis_tdata, tx_done};
      end else begin
        exp = {(c >= 1), 7'b0};
        act = {busy, 7'b0};
      end
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL reset_mid_rx c=%0d: got %b want %b", c, act, exp);
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    $display("test_reset_mid_rx: outputs cleared, zero-length start ignored");
  endtask

  initial begin
    test_reset();
    test_basic_tx();
    test_tx_underflow();
    test_rx_backpressure();
    test_arbitration();
    test_abort();
    test_reset_mid_rx();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
